// File: rtl/lmfe_pixel_feeder.sv
// lmfe_pixel_feeder: streams a raster image from a 1-cycle-latency SRAM into the median filter with busy back-pressure.
// Optional: define LMFE_FEEDER_STALL_CNT_EN to add the 16-bit stall_cnt output.
module lmfe_pixel_feeder #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic [7:0]        Din,
    output logic              in_en,
    input  logic              busy,
    output logic              frame_done,
    output logic              active
`ifdef LMFE_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W:0] LAST = NPIX - 1'b1;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W:0] issue_cnt, xfer_cnt;
    logic [1:0] occ;
    logic [2:0] credit;
    logic [7:0] tail;
    logic inflight, pop, go, last_issue, last_xfer;
    always_comb begin
        in_en      = occ != 2'd0;
        pop        = in_en && !busy;
        go         = start && (state == IDLE || state == DONE);
        credit     = 3'(occ) + 3'(inflight) - 3'(pop);
        mem_rd     = state == FETCH && credit <= 3'd1 && issue_cnt < NPIX;
        mem_addr   = issue_cnt[ADDR_W-1:0];
        last_issue = mem_rd && issue_cnt == LAST;
        last_xfer  = pop && xfer_cnt == LAST;
        active     = state == FETCH || state == DRAIN;
        state_nx   = go ? FETCH :
                     (state == FETCH && last_issue) ? DRAIN :
                     (state == DRAIN && last_xfer) ? DONE : state;
    end
    // Din is the FIFO head, tail is the second slot; the read returning now is pushed from mem_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            xfer_cnt   <= '0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            Din        <= 8'd0;
            tail       <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= state == DRAIN && state_nx == DONE;
            if (go) begin
                issue_cnt <= '0;
                xfer_cnt  <= '0;
                occ       <= 2'd0;
                inflight  <= 1'b0;
            end else begin
                inflight <= mem_rd;
                occ      <= occ + 2'(inflight) - 2'(pop);
                if (mem_rd)
                    issue_cnt <= issue_cnt + 1'b1;
                if (pop)
                    xfer_cnt <= xfer_cnt + 1'b1;
                if ((pop && (occ == 2'd2 || inflight)) || (inflight && occ == 2'd0))
                    Din <= occ == 2'd2 ? tail : mem_q;
                if (inflight && (occ == 2'd2 || (occ == 2'd1 && !pop)))
                    tail <= mem_q;
            end
        end
    end
`ifdef LMFE_FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= 16'd0;
        else if (go)
            stall_cnt <= 16'd0;
        else if (active && in_en && busy && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// tb_lmfe_pixel_feeder: directed frames with free-run, single stall, random busy, ignored start, restart and mid-frame reset.
module tb_lmfe_pixel_feeder;
    localparam int W = 128, H = 128, AW = 14, N = W * H;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy = 1'b0;
    logic mem_rd, in_en, frame_done, active;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_q = 8'd0, Din, mix = 8'd0;
`ifdef LMFE_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    lmfe_pixel_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_q(mem_q), .Din(Din), .in_en(in_en), .busy(busy), .frame_done(frame_done), .active(active)
`ifdef LMFE_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [7:0] pix(input int k);
        return 8'(k) ^ 8'(mix * 8'(k >>> 8));
    endfunction

    always @(posedge clk) if (mem_rd) mem_q <= pix(int'(mem_addr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_din"}, 32'(Din), 32'd0);
        chk({tag, "_en"}, 32'(in_en), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
`ifdef LMFE_FEEDER_STALL_CNT_EN
        chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    // mode 0: busy low (start pulsed at pixel 1000), 1: 5-cycle stall after pixel 300, 2: random busy
    task automatic run_frame(input int mode, input int reset_at, input int stop_at);
        int issued = 0, idx = 0, stalls = 0, stall_left = 0, done_k = -1;
        logic pre_rd, pre_en, pre_busy, en_m = 1'b0, ign = 1'b0;
        logic [AW-1:0] pre_addr;
        logic [7:0] pre_din;
        busy = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_active", 32'(active), 32'd1);
        chk("start_rd", 32'(mem_rd), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'd0);
        chk("start_en", 32'(in_en), 32'd0);
        for (int k = 1; k <= 4 * N; k++) begin
            busy = mode == 2 ? 1'($urandom_range(0, 1)) : stall_left > 0;
            if (stall_left > 0) stall_left--;
            if (mode == 0 && idx == 1000 && !ign) begin
                start = 1'b1;
                ign = 1'b1;
            end
            @(negedge clk);
            pre_rd = mem_rd; pre_addr = mem_addr; pre_en = in_en; pre_din = Din; pre_busy = busy;
            @(posedge clk);
            #1 start = 1'b0;
            if (pre_rd) begin
                chk("rd_addr", 32'(pre_addr), 32'(issued));
                issued++;
            end
            chk("rd_bound", 32'(issued <= N), 32'd1);
            if (en_m && pre_busy) begin
                stalls++;
                chk("hold_din", 32'(Din), 32'(pre_din));
            end
            if (pre_en && !pre_busy) begin
                chk("pixel", 32'(pre_din), 32'(pix(idx)));
                idx++;
                if (mode == 1 && idx == 301) stall_left = 5;
                if (idx == N) done_k = k;
            end
            chk("fifo_depth", 32'(issued - idx <= 2), 32'd1);
            en_m = k >= 2 && idx < N;
            chk("in_en", 32'(in_en), 32'(en_m));
            chk("frame_done", 32'(frame_done), 32'(k == done_k));
            chk("active", 32'(active), 32'(idx < N));
            if (reset_at > 0 && idx == reset_at) begin
                #2 reset = 1'b1;
                #1 zero_outputs("mid_reset");
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            if (stop_at > 0 && idx == stop_at) return;
            if (done_k > 0 && k == done_k + 3) break;
        end
        chk("done_time", 32'(done_k), 32'(N + 2 + stalls));
        chk("xfers", 32'(idx), 32'(N));
        if (mode == 1) chk("single_stalls", 32'(stalls), 32'd5);
`ifdef LMFE_FEEDER_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 zero_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1 zero_outputs("idle");
        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
        mix = 8'($urandom_range(1, 255));
        run_frame(2, 0, 0);
        run_frame(0, 5000, 0);
        mix = 8'($urandom_range(1, 255));
        run_frame(0, 0, 600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
